// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the set-associative cache controller.
//   Access-mode encoding is {cmp, write}; flush FSM state enum.
//   way_idx_w / plru_w size the way index and per-set PLRU state for WAYS = 1, 2 or 4.
package cache_pkg;

  typedef enum logic [1:0] {
    ACC_RD  = 2'b00,
    INSTALL = 2'b01,
    CMP_RD  = 2'b10,
    CMP_WR  = 2'b11
  } access_mode_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_SCAN = 2'd1,
    F_WB   = 2'd2,
    F_DONE = 2'd3
  } flush_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A single-way cache still carries a 1-bit way index so that no vector is zero-width.
  function automatic int way_idx_w(input int ways);
    return (ways > 1) ? clog2(ways) : 1;
  endfunction

  // 4 ways use a 3-bit tree; 1 and 2 ways use one bit (unused when WAYS == 1).
  function automatic int plru_w(input int ways);
    return (ways == 4) ? 3 : 1;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// cache_plru: combinational tree-PLRU victim select and update for one set.
//   Ports: bits (current PLRU state), way (way being touched),
//          victim (way to replace), bits_next (state after touching 'way').
module cache_plru
  import cache_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int WAY_W  = way_idx_w(WAYS),
  parameter int PLRU_W = plru_w(WAYS)
) (
  input  logic [PLRU_W-1:0] bits,
  input  logic [WAY_W-1:0]  way,
  output logic [WAY_W-1:0]  victim,
  output logic [PLRU_W-1:0] bits_next
);

  generate
    if (WAYS == 4) begin : g_tree4
      // bits[0]: root, 0 = victim on the left pair {0,1}, 1 = right pair {2,3}.
      // bits[1]: left pair, selects way 1 when set. bits[2]: right pair, selects way 3.
      assign victim = bits[0] ? (bits[2] ? 2'd3 : 2'd2)
                              : (bits[1] ? 2'd1 : 2'd0);
      // Touching a way points every node on its path away from it.
      assign bits_next[0] = ~way[1];
      assign bits_next[1] = way[1] ? bits[1] : ~way[0];
      assign bits_next[2] = way[1] ? ~way[0] : bits[2];
    end else if (WAYS == 2) begin : g_tree2
      // The bit holds the victim directly, so the reset value 0 selects way 0.
      assign victim    = bits;
      assign bits_next = ~way;
    end else begin : g_direct
      logic unused_way;
      assign unused_way = ^way;
      assign victim     = '0;
      assign bits_next  = bits;
    end
  endgenerate

endmodule

// File: rtl/cache_ctl_assoc.sv
// cache_ctl_assoc: N-way set-associative cache controller with tree-PLRU replacement.
//   Ports: request side (enable/ready, index, word, cmp, write, tag, data_in, valid_in),
//          result side (done, hit, dirty, valid, tag_out, data_out), flush and write-back port.
//   Optional flush engine built when CACHE_FLUSH_EN is defined; otherwise ready is tied 1
//   and all flush/write-back outputs are tied 0.
// Array updates happen at the accepting edge; results pass through one holding stage and
// appear with done one edge later. Reported fields always show the line as it was before
// the request's own update.
module cache_ctl_assoc
  import cache_pkg::*;
#(
  parameter int WAYS    = 2,
  parameter int INDEX_W = 4,
  parameter int WORD_W  = 2,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               ready,
  input  logic [INDEX_W-1:0] index,
  input  logic [WORD_W-1:0]  word,
  input  logic               cmp,
  input  logic               write,
  input  logic [TAG_W-1:0]   tag,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               valid_in,
  output logic               done,
  output logic               hit,
  output logic               dirty,
  output logic               valid,
  output logic [TAG_W-1:0]   tag_out,
  output logic [DATA_W-1:0]  data_out,
  input  logic               flush,
  output logic               flush_busy,
  output logic               flush_done,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [INDEX_W-1:0] wb_index,
  output logic [TAG_W-1:0]   wb_tag,
  output logic [WORD_W-1:0]  wb_word,
  output logic [DATA_W-1:0]  wb_data
);

  localparam int SETS   = 1 << INDEX_W;
  localparam int WORDS  = 1 << WORD_W;
  localparam int WAY_W  = way_idx_w(WAYS);
  localparam int PLRU_W = plru_w(WAYS);

  // Storage: tag/data are never reset; valid/dirty/PLRU are.
  logic [TAG_W-1:0]  tag_arr   [WAYS][SETS];
  logic [DATA_W-1:0] data_arr  [WAYS][SETS][WORDS];
  logic              valid_arr [WAYS][SETS];
  logic              dirty_arr [WAYS][SETS];
  logic [PLRU_W-1:0] plru_arr  [SETS];

  access_mode_e      mode;
  logic              accept;
  logic              hit_any;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  sel_way;
  logic [PLRU_W-1:0] plru_next;

  // Flush-engine view used by the shared state arrays.
  logic [INDEX_W-1:0] fset;
  logic [WAY_W-1:0]   fway;
  logic               flush_clr;

  // Holding stage between the accepting edge and the result registers.
  logic               s1_vld;
  logic               s1_hit;
  logic               s1_dirty;
  logic               s1_valid;
  logic [TAG_W-1:0]   s1_tag;
  logic [DATA_W-1:0]  s1_data;

  assign mode   = access_mode_e'({cmp, write});
  assign accept = enable && ready;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_arr[w][index] && (tag_arr[w][index] == tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  cache_plru #(
    .WAYS   (WAYS),
    .WAY_W  (WAY_W),
    .PLRU_W (PLRU_W)
  ) u_plru (
    .bits      (plru_arr[index]),
    .way       (hit_way),
    .victim    (victim),
    .bits_next (plru_next)
  );

  // Non-compare modes always target the victim, even when a way happens to match the tag.
  assign sel_way = (cmp && hit_any) ? hit_way : victim;

  // Tag and data arrays.
  always_ff @(posedge clk) begin
    if (accept && ((mode == INSTALL) || ((mode == CMP_WR) && hit_any))) begin
      data_arr[sel_way][index][word] <= data_in;
    end
    if (accept && (mode == INSTALL)) begin
      tag_arr[victim][index] <= tag;
    end
  end

  // Valid, dirty and PLRU state. Install leaves PLRU alone so a multi-word refill
  // keeps landing in the same way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_arr[w][s] <= 1'b0;
          dirty_arr[w][s] <= 1'b0;
        end
      end
      for (int s = 0; s < SETS; s++) begin
        plru_arr[s] <= '0;
      end
    end else begin
      if (accept) begin
        case (mode)
          CMP_RD: begin
            if (hit_any) plru_arr[index] <= plru_next;
          end
          CMP_WR: begin
            if (hit_any) begin
              dirty_arr[hit_way][index] <= 1'b1;
              plru_arr[index]           <= plru_next;
            end
          end
          INSTALL: begin
            valid_arr[victim][index] <= valid_in;
            dirty_arr[victim][index] <= 1'b0;
          end
          default: ;
        endcase
      end
      if (flush_clr) begin
        dirty_arr[fway][fset] <= 1'b0;
      end
    end
  end

  // Result pipeline: capture at the accepting edge, present with done one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_hit   <= 1'b0;
      s1_dirty <= 1'b0;
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_data  <= '0;
      done     <= 1'b0;
      hit      <= 1'b0;
      dirty    <= 1'b0;
      valid    <= 1'b0;
      tag_out  <= '0;
      data_out <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_hit   <= cmp && hit_any;
        s1_dirty <= dirty_arr[sel_way][index];
        s1_valid <= valid_arr[sel_way][index];
        s1_tag   <= tag_arr[sel_way][index];
        s1_data  <= data_arr[sel_way][index][word];
      end
      done <= s1_vld;
      if (s1_vld) begin
        hit      <= s1_hit;
        dirty    <= s1_dirty;
        valid    <= s1_valid;
        tag_out  <= s1_tag;
        data_out <= s1_data;
      end
    end
  end

`ifdef CACHE_FLUSH_EN
  flush_state_e       fstate;
  logic [WORD_W-1:0]  fword;
  logic               last_line;

  assign last_line = (fway == WAY_W'(WAYS - 1)) && (fset == {INDEX_W{1'b1}});
  assign flush_clr = (fstate == F_WB) && wb_ready && (fword == {WORD_W{1'b1}});

  // A request accepted in the same cycle as flush wins; flush must still be high next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fstate <= F_IDLE;
      fset   <= '0;
      fway   <= '0;
      fword  <= '0;
    end else begin
      case (fstate)
        F_IDLE: begin
          if (flush && !enable) begin
            fstate <= F_SCAN;
            fset   <= '0;
            fway   <= '0;
          end
        end
        F_SCAN: begin
          if (valid_arr[fway][fset] && dirty_arr[fway][fset]) begin
            fstate <= F_WB;
            fword  <= '0;
          end else if (last_line) begin
            fstate <= F_DONE;
          end else if (fway == WAY_W'(WAYS - 1)) begin
            fway <= '0;
            fset <= fset + 1'b1;
          end else begin
            fway <= fway + 1'b1;
          end
        end
        F_WB: begin
          if (wb_ready) begin
            if (fword == {WORD_W{1'b1}}) begin
              if (last_line) begin
                fstate <= F_DONE;
              end else begin
                fstate <= F_SCAN;
                if (fway == WAY_W'(WAYS - 1)) begin
                  fway <= '0;
                  fset <= fset + 1'b1;
                end else begin
                  fway <= fway + 1'b1;
                end
              end
            end else begin
              fword <= fword + 1'b1;
            end
          end
        end
        F_DONE: begin
          fstate <= F_IDLE;
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end

  assign ready      = (fstate == F_IDLE);
  assign flush_busy = (fstate != F_IDLE);
  assign flush_done = (fstate == F_DONE);
  assign wb_valid   = (fstate == F_WB);
  // Counters are frozen while a word waits for wb_ready, which keeps wb_* stable.
  assign wb_index   = wb_valid ? fset : '0;
  assign wb_tag     = wb_valid ? tag_arr[fway][fset] : '0;
  assign wb_word    = wb_valid ? fword : '0;
  assign wb_data    = wb_valid ? data_arr[fway][fset][fword] : '0;
`else
  logic unused_flush_inputs;
  assign unused_flush_inputs = flush ^ wb_ready;

  assign fset       = '0;
  assign fway       = '0;
  assign flush_clr  = 1'b0;
  assign ready      = 1'b1;
  assign flush_busy = 1'b0;
  assign flush_done = 1'b0;
  assign wb_valid   = 1'b0;
  assign wb_index   = '0;
  assign wb_tag     = '0;
  assign wb_word    = '0;
  assign wb_data    = '0;
`endif

endmodule
